// File: rtl/stream_line_capture.sv
`default_nettype none
// ============================================================================
//  Module      : stream_line_capture
//  Description : AXI4-Stream video line capture. Receives packed 24-bit RGB
//                (4 pixels per 3 words, tuser = start of frame, tlast = end
//                of line), thresholds the red byte of every pixel to one bit
//                and writes each assembled row into a row-addressed line RAM.
//                Pixel x of a row lands at bit X_SIZE-1-x.
//  Ports       : in_stream_aclk    - clock
//                periph_reset      - synchronous active-high reset
//                capture_en        - frame is captured if high on its SOF beat
//                in_stream_t*      - AXI4-Stream slave (tkeep is ignored)
//                bram_addr/din/we  - registered row write port
//                frame_done        - pulses with the write of the last row
//                len_err_cnt       - saturating count of bad-length lines
//                sof_err_cnt       - saturating count of unexpected SOFs
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_line_capture #(
    parameter int         X_SIZE    = 1280,
    parameter int         Y_SIZE    = 720,
    parameter logic [7:0] THRESHOLD = 8'h80
) (
    input  logic              in_stream_aclk,
    input  logic              periph_reset,
    input  logic              capture_en,
    input  logic [31:0]       in_stream_tdata,
    input  logic [3:0]        in_stream_tkeep,
    input  logic              in_stream_tlast,
    input  logic              in_stream_tuser,
    input  logic              in_stream_tvalid,
    output logic              in_stream_tready,
    output logic [9:0]        bram_addr,
    output logic [X_SIZE-1:0] bram_din,
    output logic              bram_we,
    output logic              frame_done,
    output logic [15:0]       len_err_cnt,
    output logic [15:0]       sof_err_cnt
);

    localparam int         c_IDX_W     = $clog2(X_SIZE);
    localparam logic [9:0] c_LAST_WORD = 10'(X_SIZE * 3 / 4 - 1);
    localparam logic [9:0] c_LAST_ROW  = 10'(Y_SIZE - 1);

    localparam logic [1:0] c_WAIT_SOF = 2'd0;
    localparam logic [1:0] c_ACTIVE   = 2'd1;
    localparam logic [1:0] c_DISCARD  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [9:0]         r_word;
    logic [10:0]        r_pix;
    logic [9:0]         r_row;
    logic [X_SIZE-1:0]  r_line;
    logic               r_tready;
    logic               r_bram_we;
    logic               r_frame_done;
    logic [9:0]         r_bram_addr;
    logic [X_SIZE-1:0]  r_bram_din;
    logic [15:0]        r_len_err;
    logic [15:0]        r_sof_err;

    logic               w_beat;
    logic               w_first_slot;
    logic               w_sof_err;
    logic               w_sof_take;
    logic               w_take;
    logic [9:0]         w_word;
    logic [10:0]        w_pix;
    logic [9:0]         w_row;
    logic               w_end_word;
    logic               w_last_row;
    logic               w_disc_end;
    logic               w_good;
    logic               w_len_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_IDX_W-1:0] w_idx_lo;
    logic [10:0]        w_pix_inc;
    logic [X_SIZE-1:0]  w_line_next;
    logic               w_unused;

    // tkeep is always all-ones from the source and carries no information.
    assign w_unused = ^in_stream_tkeep;

    assign w_beat       = in_stream_tvalid && r_tready;
    // The only place a tuser is expected inside a frame is its very first word.
    assign w_first_slot = (r_state == c_ACTIVE) && (r_word == '0) && (r_row == '0);
    assign w_sof_err    = w_beat && in_stream_tuser && (r_state != c_WAIT_SOF) && !w_first_slot;
    // An SOF beat (expected or not) restarts capture at word 0 / row 0.
    assign w_sof_take   = w_beat && in_stream_tuser && capture_en
                          && ((r_state == c_WAIT_SOF) || w_sof_err);
    assign w_take       = w_sof_take || (w_beat && (r_state == c_ACTIVE) && !w_sof_err);

    // Effective position of the beat being taken: a restarting SOF beat is
    // treated as the first word of row 0 regardless of the current counters.
    assign w_word     = w_sof_take ? '0 : r_word;
    assign w_pix      = w_sof_take ? '0 : r_pix;
    assign w_row      = w_sof_take ? '0 : r_row;
    assign w_end_word = (w_word == c_LAST_WORD);
    assign w_last_row = (w_row == c_LAST_ROW);
    assign w_disc_end = w_beat && (r_state == c_DISCARD) && !in_stream_tuser && in_stream_tlast;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge in_stream_aclk) begin
        if (periph_reset) begin
            r_state <= c_WAIT_SOF;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_take) begin
            if (in_stream_tlast) begin
                w_state_next = w_last_row ? c_WAIT_SOF : c_ACTIVE;
            end else if (w_end_word) begin
                w_state_next = c_DISCARD;
            end else begin
                w_state_next = c_ACTIVE;
            end
        end else if (w_sof_err) begin
            // Unexpected SOF with capture disabled: abandon the frame.
            w_state_next = c_WAIT_SOF;
        end else if (w_disc_end) begin
            w_state_next = w_last_row ? c_WAIT_SOF : c_ACTIVE;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_good    = w_take && in_stream_tlast && w_end_word;
        w_len_err = w_take && (in_stream_tlast ? !w_end_word : w_end_word);
    end

    // ------------------------------------------------------------------
    // Pixel insertion. The word phase follows from the pixel count:
    // phase 0 starts at pix%4==0 (two reds), phase 1 at pix%4==2,
    // phase 2 at pix%4==3.
    // ------------------------------------------------------------------
    always_comb begin
        w_line_next = r_line;
        w_idx       = c_IDX_W'(X_SIZE - 1) - c_IDX_W'(w_pix);
        w_idx_lo    = w_idx - c_IDX_W'(1);
        w_pix_inc   = (w_pix[1:0] == 2'd0) ? 11'd2 : 11'd1;
        if (w_take) begin
            case (w_pix[1:0])
                2'd0: begin
                    w_line_next[w_idx]    = (in_stream_tdata[7:0]   >= THRESHOLD);
                    w_line_next[w_idx_lo] = (in_stream_tdata[31:24] >= THRESHOLD);
                end
                2'd2:    w_line_next[w_idx] = (in_stream_tdata[23:16] >= THRESHOLD);
                2'd3:    w_line_next[w_idx] = (in_stream_tdata[15:8]  >= THRESHOLD);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge in_stream_aclk) begin
        if (periph_reset) begin
            r_tready     <= 1'b0;
            r_bram_we    <= 1'b0;
            r_frame_done <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
            r_len_err    <= '0;
            r_sof_err    <= '0;
            r_word       <= '0;
            r_pix        <= '0;
            r_row        <= '0;
            r_line       <= '0;
        end else begin
            r_tready     <= 1'b1;
            r_bram_we    <= w_good;
            r_frame_done <= w_good && w_last_row;
            if (w_good) begin
                r_bram_addr <= w_row;
                r_bram_din  <= w_line_next;
            end
            if (w_len_err && (r_len_err != 16'hFFFF)) begin
                r_len_err <= r_len_err + 16'd1;
            end
            if (w_sof_err && (r_sof_err != 16'hFFFF)) begin
                r_sof_err <= r_sof_err + 16'd1;
            end

            if (w_take) begin
                r_line <= w_line_next;
                if (in_stream_tlast) begin
                    r_word <= '0;
                    r_pix  <= '0;
                    r_row  <= w_last_row ? '0 : (w_row + 10'd1);
                end else if (w_end_word) begin
                    r_word <= '0;
                    r_pix  <= '0;
                    r_row  <= w_row;
                end else begin
                    r_word <= w_word + 10'd1;
                    r_pix  <= w_pix + w_pix_inc;
                    r_row  <= w_row;
                end
            end else if (w_sof_err) begin
                r_word <= '0;
                r_pix  <= '0;
                r_row  <= '0;
            end else if (w_disc_end) begin
                r_row <= w_last_row ? '0 : (r_row + 10'd1);
            end
        end
    end

    assign in_stream_tready = r_tready;
    assign bram_we          = r_bram_we;
    assign frame_done       = r_frame_done;
    assign bram_addr        = r_bram_addr;
    assign bram_din         = r_bram_din;
    assign len_err_cnt      = r_len_err;
    assign sof_err_cnt      = r_sof_err;

endmodule
`default_nettype wire

// File: tb/tb_stream_line_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_line_capture
//  Description : Self-checking bench for stream_line_capture using a reduced
//                frame geometry, randomized pixel data and tvalid gaps, and a
//                line-level reference model built from the byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_line_capture;

    localparam int         X   = 32;
    localparam int         Y   = 12;
    localparam int         W   = X * 3 / 4;
    localparam logic [7:0] THR = 8'h80;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          capture_en = 1'b0;
    logic [31:0]   tdata      = '0;
    logic [3:0]    tkeep      = 4'hF;
    logic          tlast      = 1'b0;
    logic          tuser      = 1'b0;
    logic          tvalid     = 1'b0;
    logic          tready;
    logic [9:0]    bram_addr;
    logic [X-1:0]  bram_din;
    logic          bram_we;
    logic          frame_done;
    logic [15:0]   len_err_cnt;
    logic [15:0]   sof_err_cnt;

    stream_line_capture #(.X_SIZE(X), .Y_SIZE(Y), .THRESHOLD(THR)) u_dut (
        .in_stream_aclk  (clk),
        .periph_reset    (rst),
        .capture_en      (capture_en),
        .in_stream_tdata (tdata),
        .in_stream_tkeep (tkeep),
        .in_stream_tlast (tlast),
        .in_stream_tuser (tuser),
        .in_stream_tvalid(tvalid),
        .in_stream_tready(tready),
        .bram_addr       (bram_addr),
        .bram_din        (bram_din),
        .bram_we         (bram_we),
        .frame_done      (frame_done),
        .len_err_cnt     (len_err_cnt),
        .sof_err_cnt     (sof_err_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [9:0]   addr;
        logic [X-1:0] data;
        logic         fd;
        int           cyc;
    } wr_t;

    wr_t          exp_q[$];
    logic [7:0]   m_bytes[$];       // bytes of the line being collected
    int           m_mode = 0;       // 0 idle until SOF, 1 collecting, 2 skipping to tlast
    int           m_row  = 0;
    int           m_len  = 0;
    int           m_sof  = 0;
    logic [X-1:0] m_mem[Y];
    logic [X-1:0] d_mem[Y];

    task automatic m_next_row();
        m_bytes.delete();
        m_row++;
        if (m_row == Y) begin
            m_row  = 0;
            m_mode = 0;
        end else begin
            m_mode = 1;
        end
    endtask

    task automatic model_beat(input logic [31:0] d, input bit last, input bit user,
                              input bit capv, input int at);
        bit           restart;
        wr_t          e;
        logic [X-1:0] row;
        restart = 1'b0;
        if (user) begin
            if (m_mode != 0 && !(m_mode == 1 && m_bytes.size() == 0 && m_row == 0)) begin
                restart = 1'b1;
                if (m_sof < 65535) m_sof++;
            end
            if (m_mode == 0 || restart) begin
                m_bytes.delete();
                m_row = 0;
                if (capv) m_mode = 1;
                else begin
                    m_mode = 0;
                    return;
                end
            end
        end
        if (m_mode == 0) return;
        if (m_mode == 2) begin
            if (last) m_next_row();
            return;
        end
        for (int k = 0; k < 4; k++) m_bytes.push_back(d[8*k +: 8]);
        if (last) begin
            if (m_bytes.size() == 4 * W) begin
                row = '0;
                for (int x = 0; x < X; x++) row[X-1-x] = (m_bytes[3*x] >= THR);
                e.addr = 10'(m_row);
                e.data = row;
                e.fd   = (m_row == Y - 1);
                e.cyc  = at;
                exp_q.push_back(e);
                m_mem[m_row] = row;
            end else if (m_len < 65535) begin
                m_len++;
            end
            m_next_row();
        end else if (m_bytes.size() == 4 * W) begin
            if (m_len < 65535) m_len++;
            m_mode = 2;
            m_bytes.delete();
        end
    endtask

    // ---------------- write monitor ----------------
    int n_wr = 0;
    int n_fd = 0;
    int last_fd_addr = -1;
    int wr_log[$];

    always @(negedge clk) begin
        wr_t e;
        if (frame_done) chk("fd_with_we", bram_we, 1);
        if (bram_we) begin
            n_wr++;
            wr_log.push_back(int'(bram_addr));
            if (frame_done) begin
                n_fd++;
                last_fd_addr = int'(bram_addr);
            end
            if (bram_addr < Y) d_mem[bram_addr] = bram_din;
            chk("wr_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_addr", bram_addr, e.addr);
                chk("wr_data", bram_din, e.data);
                chk("wr_fd", frame_done, e.fd);
                chk("wr_latency", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    int gap_pct = 0;

    function automatic logic [7:0] red_of(input int pat, input int x, input int y, input int seed);
        case (pat)
            0:       return (x == y) ? 8'hFF : 8'h00;
            1:       return x[0] ? 8'h80 : 8'h7F;
            default: return 8'((x * 73 + y * 151 + seed * 29) ^ (x * y * 7));
        endcase
    endfunction

    task automatic beat(input logic [31:0] d, input bit last, input bit user, input bit capv);
        while ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            tvalid     = 1'b0;
            tdata      = $urandom;
            tlast      = 1'($urandom);
            tuser      = 1'($urandom);
            capture_en = 1'($urandom);
        end
        @(negedge clk);
        tdata      = d;
        tlast      = last;
        tuser      = user;
        capture_en = capv;
        tvalid     = 1'b1;
        model_beat(d, last, user, capv, cyc + 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tvalid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        tvalid = 1'b0;
        rst    = 1'b1;
        m_mode = 0;
        m_row  = 0;
        m_len  = 0;
        m_sof  = 0;
        m_bytes.delete();
        @(negedge clk);
        chk("rst_tready", tready, 0);
        chk("rst_we", bram_we, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_din", bram_din, 0);
        chk("rst_len_cnt", len_err_cnt, 0);
        chk("rst_sof_cnt", sof_err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("tready_after_rst", tready, 1);
    endtask

    task automatic send_line(input int pat, input int y, input int seed, input int nw,
                             input bit has_last, input bit sof, input bit capv, input int rst_at);
        logic [7:0]  b[$];
        logic [31:0] d;
        for (int i = 0; i < nw * 4; i++) begin
            if ((i % 3 == 0) && (i / 3 < X)) b.push_back(red_of(pat, i / 3, y, seed));
            else b.push_back(8'($urandom));
        end
        for (int w = 0; w < nw; w++) begin
            if (w == rst_at) do_reset();
            d = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
            beat(d, has_last && (w == nw - 1), sof && (w == 0),
                 (sof && (w == 0)) ? capv : 1'($urandom));
        end
    endtask

    task automatic send_frame(input int pat, input int seed, input bit capv, input int short_row,
                              input int long_row, input int trunc_row, input int rst_row);
        int nw;
        for (int y = 0; y < Y; y++) begin
            if (y == trunc_row) begin
                send_line(pat, y, seed, 10, 1'b0, y == 0, capv, -1);
                return;
            end
            nw = (y == short_row) ? (W * 3) / 4 : (y == long_row) ? W + 4 : W;
            send_line(pat, y, seed, nw, 1'b1, y == 0, capv, (y == rst_row) ? W / 2 : -1);
        end
    endtask

    task automatic settle();
        idle(4);
        chk("len_err_cnt", len_err_cnt, 16'(m_len));
        chk("sof_err_cnt", sof_err_cnt, 16'(m_sof));
        chk("exp_q_drained", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int           w0;
        int           f0;
        logic [X-1:0] onehot;
        logic [X-1:0] snap[Y];
        logic [X-1:0] s3, s5, s6;
        int           sr, lr;

        for (int y = 0; y < Y; y++) begin
            m_mem[y] = '0;
            d_mem[y] = '0;
        end
        do_reset();

        // diagonal frame at full rate
        w0 = n_wr;
        f0 = n_fd;
        send_frame(0, 0, 1'b1, -1, -1, -1, -1);
        settle();
        chk("diag_writes", n_wr - w0, Y);
        chk("diag_fd_count", n_fd - f0, 1);
        chk("diag_fd_addr", last_fd_addr, Y - 1);
        for (int y = 0; y < Y; y++) begin
            onehot = '0;
            onehot[X-1-y] = 1'b1;
            chk("diag_row", d_mem[y], onehot);
        end

        // threshold boundary 7F / 80 alternating
        send_frame(1, 0, 1'b1, -1, -1, -1, -1);
        settle();
        chk("alt_row", d_mem[4], {(X/2){2'b01}});

        // same frame with and without tvalid gaps
        send_frame(2, 7, 1'b1, -1, -1, -1, -1);
        settle();
        snap = d_mem;
        send_frame(0, 0, 1'b1, -1, -1, -1, -1);
        gap_pct = 30;
        send_frame(2, 7, 1'b1, -1, -1, -1, -1);
        gap_pct = 0;
        settle();
        for (int y = 0; y < Y; y++) chk("gap_row", d_mem[y], snap[y]);

        // short row 5, long row 6
        s5 = d_mem[5];
        s6 = d_mem[6];
        send_frame(2, 3, 1'b1, 5, 6, -1, -1);
        settle();
        chk("len_err_two", len_err_cnt, 2);
        chk("short_row_kept", d_mem[5], s5);
        chk("long_row_kept", d_mem[6], s6);
        chk("row7_written", d_mem[7], m_mem[7]);

        // SOF injected on word 10 of row 5
        w0 = n_wr;
        send_frame(2, 11, 1'b1, -1, -1, 5, -1);
        idle(2);
        chk("trunc_writes", n_wr - w0, 5);
        w0 = n_wr;
        send_frame(2, 12, 1'b1, -1, -1, -1, -1);
        settle();
        chk("sof_err_one", sof_err_cnt, 1);
        chk("after_sof_addr", wr_log[w0], 0);

        // capture_en low at SOF, then high
        w0 = n_wr;
        send_frame(2, 20, 1'b0, -1, -1, -1, -1);
        settle();
        chk("cap0_writes", n_wr - w0, 0);
        w0 = n_wr;
        send_frame(2, 21, 1'b1, -1, -1, -1, -1);
        settle();
        chk("cap1_writes", n_wr - w0, Y);

        // reset in the middle of row 3
        s3 = d_mem[3];
        w0 = n_wr;
        send_frame(0, 0, 1'b1, -1, -1, -1, 3);
        settle();
        chk("rst_frame_writes", n_wr - w0, 3);
        chk("rst_row_kept", d_mem[3], s3);
        w0 = n_wr;
        send_frame(2, 30, 1'b1, -1, -1, -1, -1);
        settle();
        chk("post_rst_writes", n_wr - w0, Y);

        // randomized frames
        repeat (3) begin
            gap_pct = int'($urandom_range(40));
            sr = int'($urandom_range(2 * Y - 1));
            lr = int'($urandom_range(2 * Y - 1));
            if (sr >= Y) sr = -1;
            if (lr >= Y) lr = -1;
            send_frame(2, int'($urandom_range(1000)), $urandom_range(3) != 0, sr, lr, -1, -1);
        end
        gap_pct = 0;
        settle();

        for (int y = 0; y < Y; y++) chk("mem_row", d_mem[y], m_mem[y]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
